// File: rtl/eth_axis_pkg.sv
// Shared types and helpers for the Ethernet AXI-Stream lane arbiter.
package eth_axis_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        ABORT
    } arb_state_t;

    // Abort beat marks byte 0 only
    localparam int unsigned ABORT_KEEP = 1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eth_rr_picker.sv
// Combinational rotate-priority encoder: first requester after 'last', with wrap.
module eth_rr_picker
    import eth_axis_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned LANE_W = clog2_min1(N)
) (
    input  logic [N-1:0]      req,
    input  logic [LANE_W-1:0] last,
    output logic              gnt_valid,
    output logic [LANE_W-1:0] gnt_idx
);

    int unsigned idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[LANE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/eth_axis_lane_arbiter.sv
// Packet-granular round-robin merge of N RX lanes onto one AXI-Stream, with a
// source-stall watchdog that terminates a hung packet with an error beat.
module eth_axis_lane_arbiter
    import eth_axis_pkg::*;
#(
    parameter  int unsigned N_LANES = 4,
    parameter  int unsigned DATA_W  = 64,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned KEEP_W  = DATA_W / 8,
    localparam int unsigned LANE_W  = clog2_min1(N_LANES)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [N_LANES*DATA_W-1:0]   s_tdata,
    input  logic [N_LANES*KEEP_W-1:0]   s_tkeep,
    input  logic [N_LANES-1:0]          s_tlast,
    input  logic [N_LANES-1:0]          s_tuser,
    input  logic [N_LANES-1:0]          s_tvalid,
    output logic [N_LANES-1:0]          s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic [KEEP_W-1:0]           m_tkeep,
    output logic                        m_tlast,
    output logic                        m_tuser,
    output logic [LANE_W-1:0]           m_tdest,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        abort_pulse,
    output logic [15:0]                 abort_count,
    output logic                        busy
);

    localparam int unsigned WD_W = clog2_min1(TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [LANE_W-1:0]   grant_q, grant_d;
    logic [LANE_W-1:0]   last_grant_q, last_grant_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic [N_LANES-1:0]  discard_q, discard_d;
    logic                abort_pulse_q;
    logic [15:0]         abort_count_q;
    logic                abort_acc;

    logic                gnt_valid;
    logic [LANE_W-1:0]   gnt_idx;

    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic                sel_last;
    logic                sel_user;
    logic                sel_valid;

    eth_rr_picker #(
        .N      (N_LANES),
        .LANE_W (LANE_W)
    ) u_picker (
        .req       (s_tvalid & ~discard_q),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (grant_q == LANE_W'(i)) begin
                sel_data  = s_tdata[i*DATA_W +: DATA_W];
                sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
                sel_last  = s_tlast[i];
                sel_user  = s_tuser[i];
                sel_valid = s_tvalid[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wd_cnt_d     = wd_cnt_q;
        discard_d    = discard_q;
        abort_acc    = 1'b0;
        s_tready     = discard_q;
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tlast      = 1'b0;
        m_tuser      = 1'b0;
        m_tdest      = '0;
        m_tvalid     = 1'b0;

        // Discarding lanes sink beats until their own tlast
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (discard_q[i] && s_tvalid[i] && s_tlast[i]) discard_d[i] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d  = gnt_idx;
                    wd_cnt_d = '0;
                    state_d  = PASS;
                end
            end
            PASS: begin
                m_tdata  = sel_data;
                m_tkeep  = sel_keep;
                m_tlast  = sel_last;
                m_tuser  = sel_user;
                m_tdest  = grant_q;
                m_tvalid = sel_valid;
                for (int unsigned i = 0; i < N_LANES; i++) begin
                    if (grant_q == LANE_W'(i)) s_tready[i] = m_tready;
                end
                if (sel_valid && m_tready) begin
                    wd_cnt_d = '0;
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end else if (!sel_valid && (TIMEOUT != 0)) begin
                    if (wd_cnt_q == WD_W'(TIMEOUT - 1)) state_d = ABORT;
                    else                                wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            ABORT: begin
                m_tkeep  = KEEP_W'(ABORT_KEEP);
                m_tlast  = 1'b1;
                m_tuser  = 1'b1;
                m_tdest  = grant_q;
                m_tvalid = 1'b1;
                if (m_tready) begin
                    for (int unsigned i = 0; i < N_LANES; i++) begin
                        if (grant_q == LANE_W'(i)) discard_d[i] = 1'b1;
                    end
                    abort_acc    = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= LANE_W'(N_LANES - 1);
            wd_cnt_q      <= '0;
            discard_q     <= '0;
            abort_pulse_q <= 1'b0;
            abort_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
            discard_q     <= discard_d;
            abort_pulse_q <= abort_acc;
            if (abort_acc && (abort_count_q != 16'hFFFF)) abort_count_q <= abort_count_q + 16'd1;
        end
    end

    assign abort_pulse = abort_pulse_q;
    assign abort_count = abort_count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_eth_axis_lane_arbiter.sv
// Directed bench for eth_axis_lane_arbiter (4 lanes, 64-bit, TIMEOUT=16).
module tb_eth_axis_lane_arbiter;

    logic          clock;
    logic          resetn;
    logic [255:0]  s_tdata;
    logic [31:0]   s_tkeep;
    logic [3:0]    s_tlast;
    logic [3:0]    s_tuser;
    logic [3:0]    s_tvalid;
    logic [3:0]    s_tready;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tuser;
    logic [1:0]    m_tdest;
    logic          m_tvalid;
    logic          m_tready;
    logic          abort_pulse;
    logic [15:0]   abort_count;
    logic          busy;

    logic [63:0]   td [4];
    logic [7:0]    tk [4];
    int            n_checks;
    int            n_pass;

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign s_tdata[i*64 +: 64] = td[i];
        assign s_tkeep[i*8 +: 8]   = tk[i];
    end

    eth_axis_lane_arbiter #(
        .N_LANES (4),
        .DATA_W  (64),
        .TIMEOUT (16)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .m_tdest     (m_tdest),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .abort_pulse (abort_pulse),
        .abort_count (abort_count),
        .busy        (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int lane, input logic v, input logic l, input logic u,
                         input logic [63:0] d, input logic [7:0] k);
        s_tvalid[lane] = v;
        s_tlast[lane]  = l;
        s_tuser[lane]  = u;
        td[lane]       = d;
        tk[lane]       = k;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        logic [63:0] pkt [3];
        int          exp_lane;
        int          prev_lane;

        n_checks = 0;
        n_pass   = 0;
        m_tready = 1'b1;
        resetn   = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        for (int i = 0; i < 4; i++) begin
            td[i] = '0;
            tk[i] = '0;
        end

        // Reset state
        do_reset();
        @(negedge clock);
        check("rst_tready", 64'(s_tready), 64'h0);
        check("rst_tvalid", 64'(m_tvalid), 64'h0);
        check("rst_busy",   64'(busy), 64'h0);
        check("rst_count",  64'(abort_count), 64'h0);
        check("rst_tdata",  m_tdata, 64'h0);

        // Lane 0, 3-beat packet: bubble cycle then zero-latency pass-through
        pkt[0] = 64'h1111_0000_AAAA_0001;
        pkt[1] = 64'h2222_0000_BBBB_0002;
        pkt[2] = 64'h3333_0000_CCCC_0003;
        tick();
        drive(0, 1'b1, 1'b0, 1'b0, pkt[0], 8'hFF);
        @(negedge clock);
        check("t1_bubble", 64'(m_tvalid), 64'h0);
        tick();
        for (int b = 0; b < 3; b++) begin
            drive(0, 1'b1, (b == 2), 1'b0, pkt[b], (b == 2) ? 8'h3F : 8'hFF);
            @(negedge clock);
            check("t1_valid", 64'(m_tvalid), 64'h1);
            check("t1_data",  m_tdata, pkt[b]);
            check("t1_keep",  64'(m_tkeep), (b == 2) ? 64'h3F : 64'hFF);
            check("t1_last",  64'(m_tlast), (b == 2) ? 64'h1 : 64'h0);
            check("t1_dest",  64'(m_tdest), 64'h0);
            check("t1_ready", 64'(s_tready), 64'h1);
            tick();
        end
        drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        @(negedge clock);
        check("t1_idle", 64'(busy), 64'h0);

        // All lanes streaming 1-beat packets: round-robin from lane 0 after reset
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 1'b0, 64'hD0 + 64'(i), 8'hFF);
        prev_lane = 3;
        for (int p = 0; p < 5; p++) begin
            exp_lane = p % 4;
            tick();
            @(negedge clock);
            check("t2_valid", 64'(m_tvalid), 64'h1);
            check("t2_dest",  64'(m_tdest), 64'(exp_lane));
            check("t2_data",  m_tdata, 64'hD0 + 64'(exp_lane));
            check("t2_ready", 64'(s_tready), 64'(1 << exp_lane));
            check("t2_norep", 64'(int'(m_tdest) != prev_lane), 64'h1);
            prev_lane = int'(m_tdest);
            tick();
            @(negedge clock);
            check("t2_bubble", 64'(m_tvalid), 64'h0);
        end
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);

        // Lane 1 mid-packet under long back-pressure: watchdog must not fire
        drive(1, 1'b1, 1'b0, 1'b0, 64'h5100, 8'hFF);
        tick();
        tick();
        drive(1, 1'b1, 1'b0, 1'b0, 64'h5101, 8'hFF);
        m_tready = 1'b0;
        repeat (5000) tick();
        @(negedge clock);
        check("t3_hold_valid", 64'(m_tvalid), 64'h1);
        check("t3_hold_data",  m_tdata, 64'h5101);
        check("t3_hold_dest",  64'(m_tdest), 64'h1);
        check("t3_hold_user",  64'(m_tuser), 64'h0);
        check("t3_no_abort",   64'(abort_count), 64'h0);
        m_tready = 1'b1;
        tick();
        drive(1, 1'b1, 1'b1, 1'b0, 64'h5102, 8'h0F);
        @(negedge clock);
        check("t3_tail_data", m_tdata, 64'h5102);
        check("t3_tail_last", 64'(m_tlast), 64'h1);
        tick();
        drive(1, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        @(negedge clock);
        check("t3_done", 64'(busy), 64'h0);

        // Lane 2 stalls after 2 beats: abort on 16th stall cycle, rest sunk
        drive(2, 1'b1, 1'b0, 1'b0, 64'h4200, 8'hFF);
        tick();
        tick();
        drive(2, 1'b1, 1'b0, 1'b0, 64'h4201, 8'hFF);
        tick();
        drive(2, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        repeat (15) tick();
        @(negedge clock);
        check("t4_pre_busy",  64'(busy), 64'h1);
        check("t4_pre_valid", 64'(m_tvalid), 64'h0);
        tick();
        @(negedge clock);
        check("t4_ab_valid", 64'(m_tvalid), 64'h1);
        check("t4_ab_last",  64'(m_tlast), 64'h1);
        check("t4_ab_user",  64'(m_tuser), 64'h1);
        check("t4_ab_keep",  64'(m_tkeep), 64'h01);
        check("t4_ab_dest",  64'(m_tdest), 64'h2);
        check("t4_ab_data",  m_tdata, 64'h0);
        check("t4_ab_ready", 64'(s_tready), 64'h0);
        tick();
        @(negedge clock);
        check("t4_pulse",  64'(abort_pulse), 64'h1);
        check("t4_count",  64'(abort_count), 64'h1);
        check("t4_idle",   64'(busy), 64'h0);
        check("t4_sink",   64'(s_tready), 64'h4);
        drive(2, 1'b1, 1'b0, 1'b0, 64'h4202, 8'hFF);
        tick();
        @(negedge clock);
        check("t4_pulse_end", 64'(abort_pulse), 64'h0);
        check("t4_sunk_valid", 64'(m_tvalid), 64'h0);
        check("t4_sunk_ready", 64'(s_tready), 64'h4);
        drive(2, 1'b1, 1'b1, 1'b0, 64'h4203, 8'hFF);
        tick();
        drive(2, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        @(negedge clock);
        check("t4_cleared", 64'(s_tready), 64'h0);
        check("t4_no_grant", 64'(busy), 64'h0);

        // Lane 3 stall ends exactly when counter reaches TIMEOUT-1
        drive(3, 1'b1, 1'b0, 1'b0, 64'h6300, 8'hFF);
        tick();
        tick();
        drive(3, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        repeat (15) tick();
        drive(3, 1'b1, 1'b1, 1'b0, 64'h6301, 8'h0F);
        @(negedge clock);
        check("t5_valid", 64'(m_tvalid), 64'h1);
        check("t5_data",  m_tdata, 64'h6301);
        check("t5_user",  64'(m_tuser), 64'h0);
        check("t5_keep",  64'(m_tkeep), 64'h0F);
        tick();
        drive(3, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        @(negedge clock);
        check("t5_count", 64'(abort_count), 64'h1);
        check("t5_idle",  64'(busy), 64'h0);

        // Reset mid-packet on lane 3, then lane 0 has priority
        drive(3, 1'b1, 1'b0, 1'b0, 64'h7300, 8'hFF);
        tick();
        @(negedge clock);
        check("t6_dest3", 64'(m_tdest), 64'h3);
        tick();
        drive(3, 1'b1, 1'b0, 1'b0, 64'h7301, 8'hFF);
        drive(0, 1'b1, 1'b1, 1'b0, 64'h7000, 8'hFF);
        resetn = 1'b0;
        tick();
        @(negedge clock);
        check("t6_valid", 64'(m_tvalid), 64'h0);
        check("t6_ready", 64'(s_tready), 64'h0);
        check("t6_busy",  64'(busy), 64'h0);
        check("t6_data",  m_tdata, 64'h0);
        check("t6_keep",  64'(m_tkeep), 64'h0);
        check("t6_last",  64'(m_tlast), 64'h0);
        check("t6_user",  64'(m_tuser), 64'h0);
        check("t6_dest",  64'(m_tdest), 64'h0);
        check("t6_count", 64'(abort_count), 64'h0);
        check("t6_pulse", 64'(abort_pulse), 64'h0);
        resetn = 1'b1;
        tick();
        @(negedge clock);
        check("t6_first_dest", 64'(m_tdest), 64'h0);
        check("t6_first_data", m_tdata, 64'h7000);
        tick();
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
